// File: rtl/mem_stage_if.sv
// Bundle of EX-side inputs, stall/flush controls and WB-side outputs for the MEM stage.
// The stage owns the slave view; whoever drives EX results and samples WB owns the master view.
interface mem_stage_if;
    logic        stall;
    logic        flush;
    logic        ex_wreg;
    logic        ex_m2reg;
    logic        ex_wmem;
    logic [31:0] ex_aluR;
    logic [31:0] ex_b;
    logic [4:0]  ex_destR;
    logic [3:0]  EX_ins_type;
    logic [3:0]  EX_ins_number;

    logic        mem_wreg;
    logic        mem_m2reg;
    logic [31:0] mem_aluR;
    logic [31:0] mem_mdata;
    logic [4:0]  mem_destR;
    logic [3:0]  MEM_ins_type;
    logic [3:0]  MEM_ins_number;
    logic [31:0] mem_fwd_data;
    logic        mem_misalign;

    modport master (
        output stall, flush, ex_wreg, ex_m2reg, ex_wmem, ex_aluR, ex_b, ex_destR,
               EX_ins_type, EX_ins_number,
        input  mem_wreg, mem_m2reg, mem_aluR, mem_mdata, mem_destR, MEM_ins_type,
               MEM_ins_number, mem_fwd_data, mem_misalign
    );

    modport slave (
        input  stall, flush, ex_wreg, ex_m2reg, ex_wmem, ex_aluR, ex_b, ex_destR,
               EX_ins_type, EX_ins_number,
        output mem_wreg, mem_m2reg, mem_aluR, mem_mdata, mem_destR, MEM_ins_type,
               MEM_ins_number, mem_fwd_data, mem_misalign
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register with stall/flush plus a word-addressed data memory.
// Loads are combinational from the registered address; stores commit at the edge ending MEM.
module mem_stage #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input logic         clk,
    input logic         rst,
    mem_stage_if.slave  bus
);
    logic              r_wreg;
    logic              r_m2reg;
    logic              r_wmem;
    logic [31:0]       r_aluR;
    logic [31:0]       r_b;
    logic [4:0]        r_destR;
    logic [3:0]        r_type;
    logic [3:0]        r_num;
    logic [31:0]       r_mem [DEPTH];

    logic [ADDR_W-1:0] w_index;
    logic              w_misalign;
    logic              w_store;
    logic              w_m2reg_out;
    logic [31:0]       w_mdata;

    // Upper address bits are ignored, so accesses wrap modulo DEPTH words.
    assign w_index    = r_aluR[ADDR_W+1:2];
    assign w_misalign = (r_m2reg | r_wmem) & (|r_aluR[1:0]);
    assign w_store    = r_wmem & ~bus.stall & ~w_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wreg  <= 1'b0;
            r_m2reg <= 1'b0;
            r_wmem  <= 1'b0;
            r_aluR  <= '0;
            r_b     <= '0;
            r_destR <= '0;
            r_type  <= '0;
            r_num   <= '0;
        end else if (bus.flush) begin
            r_wreg  <= 1'b0;
            r_m2reg <= 1'b0;
            r_wmem  <= 1'b0;
            r_aluR  <= '0;
            r_b     <= '0;
            r_destR <= '0;
            r_type  <= '0;
            r_num   <= '0;
        end else if (!bus.stall) begin
            r_wreg  <= bus.ex_wreg;
            r_m2reg <= bus.ex_m2reg;
            r_wmem  <= bus.ex_wmem;
            r_aluR  <= bus.ex_aluR;
            r_b     <= bus.ex_b;
            r_destR <= bus.ex_destR;
            r_type  <= bus.EX_ins_type;
            r_num   <= bus.EX_ins_number;
        end
    end

    // Store uses the instruction currently in MEM, so a flush of EX does not cancel it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_store) begin
            r_mem[w_index] <= r_b;
        end
    end

    assign w_mdata     = r_mem[w_index];
    assign w_m2reg_out = r_m2reg & ~bus.stall;

    // A stalled instruction is presented to WB as a bubble while its fields are held.
    assign bus.mem_wreg       = r_wreg & ~bus.stall;
    assign bus.mem_m2reg      = w_m2reg_out;
    assign bus.mem_aluR       = r_aluR;
    assign bus.mem_mdata      = w_mdata;
    assign bus.mem_destR      = r_destR;
    assign bus.MEM_ins_type   = bus.stall ? 4'd0 : r_type;
    assign bus.MEM_ins_number = r_num;
    assign bus.mem_fwd_data   = w_m2reg_out ? w_mdata : r_aluR;
    assign bus.mem_misalign   = w_misalign;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed checks of mem_stage against a behavioural pipeline/memory model.
module tb_mem_stage;
  typedef struct {
    bit        wreg;
    bit        m2reg;
    bit        wmem;
    bit [31:0] alu;
    bit [31:0] b;
    bit [4:0]  dest;
    bit [3:0]  typ;
    bit [3:0]  num;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mem_stage_if bus();

  mem_stage #(.DEPTH(64), .ADDR_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  ins_t      slot;
  ins_t      cur_in;
  bit        cur_stall;
  bit        cur_flush;
  bit [31:0] ref_mem [64];
  bit [3:0]  seq_num = 4'd0;

  function automatic ins_t mk_nop();
    ins_t x;
    x = '{default: 0};
    return x;
  endfunction

  function automatic ins_t mk_store(bit [31:0] addr, bit [31:0] data);
    ins_t x;
    x = '{default: 0};
    x.wmem = 1'b1; x.alu = addr; x.b = data; x.typ = 4'd2;
    x.num = seq_num; seq_num++;
    return x;
  endfunction

  function automatic ins_t mk_load(bit [31:0] addr);
    ins_t x;
    x = '{default: 0};
    x.wreg = 1'b1; x.m2reg = 1'b1; x.alu = addr; x.typ = 4'd1;
    x.dest = 5'($urandom_range(1, 31)); x.num = seq_num; seq_num++;
    return x;
  endfunction

  function automatic ins_t mk_alu(bit [31:0] res);
    ins_t x;
    x = '{default: 0};
    x.wreg = 1'b1; x.alu = res; x.typ = 4'd3; x.b = $urandom;
    x.dest = 5'($urandom_range(1, 31)); x.num = seq_num; seq_num++;
    return x;
  endfunction

  task automatic put(ins_t x, bit st, bit fl);
    cur_in = x; cur_stall = st; cur_flush = fl;
    bus.ex_wreg = x.wreg; bus.ex_m2reg = x.m2reg; bus.ex_wmem = x.wmem;
    bus.ex_aluR = x.alu; bus.ex_b = x.b; bus.ex_destR = x.dest;
    bus.EX_ins_type = x.typ; bus.EX_ins_number = x.num;
    bus.stall = st; bus.flush = fl;
  endtask

  // One clock: the model applies what the edge does -- the instruction leaving MEM stores
  // (if not stalled and word aligned), then the pipeline slot takes bubble/hold/new.
  task automatic tick();
    @(posedge clk);
    #1;
    if (slot.wmem && !cur_stall && slot.alu[1:0] == 2'b00)
      ref_mem[slot.alu[7:2]] = slot.b;
    if (cur_flush) slot = mk_nop();
    else if (!cur_stall) slot = cur_in;
  endtask

  function automatic bit [31:0] model_mdata();
    return ref_mem[slot.alu[7:2]];
  endfunction

  task automatic test_reset();
    put(mk_nop(), 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    slot = mk_nop();
    foreach (ref_mem[i]) ref_mem[i] = '0;
    total++; if (bus.mem_wreg !== 1'b0) begin bad++; $display("FAIL reset_wreg got=%0b exp=0", bus.mem_wreg); end
    total++; if (bus.mem_aluR !== 32'd0) begin bad++; $display("FAIL reset_aluR got=%h exp=0", bus.mem_aluR); end
    total++; if (bus.mem_mdata !== 32'd0) begin bad++; $display("FAIL reset_mdata got=%h exp=0", bus.mem_mdata); end
    total++; if (bus.MEM_ins_number !== 4'd0) begin bad++; $display("FAIL reset_num got=%h exp=0", bus.MEM_ins_number); end
    total++; if (bus.mem_misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%0b exp=0", bus.mem_misalign); end
  endtask

  task automatic test_store_load();
    put(mk_store(32'h10, 32'hDEADBEEF), 1'b0, 1'b0); tick();
    total++; if (bus.mem_misalign !== 1'b0) begin bad++; $display("FAIL sl_misalign got=%0b exp=0", bus.mem_misalign); end
    put(mk_load(32'h10), 1'b0, 1'b0); tick();
    total++; if (bus.mem_mdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sl_mdata got=%h exp=deadbeef", bus.mem_mdata); end
    total++; if (bus.mem_fwd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL sl_fwd got=%h exp=deadbeef", bus.mem_fwd_data); end
    total++; if (bus.mem_m2reg !== 1'b1 || bus.mem_wreg !== 1'b1) begin bad++; $display("FAIL sl_ctrl got=%0b%0b exp=11", bus.mem_m2reg, bus.mem_wreg); end
    total++; if (bus.mem_destR !== slot.dest) begin bad++; $display("FAIL sl_dest got=%0d exp=%0d", bus.mem_destR, slot.dest); end
  endtask

  task automatic test_wrap();
    put(mk_store(32'h100, 32'h12345678), 1'b0, 1'b0); tick();
    put(mk_load(32'h0), 1'b0, 1'b0); tick();
    total++; if (bus.mem_mdata !== 32'h12345678) begin bad++; $display("FAIL wrap_mdata got=%h exp=12345678", bus.mem_mdata); end
    put(mk_alu(32'hCAFE0001), 1'b0, 1'b0); tick();
    total++; if (bus.mem_fwd_data !== 32'hCAFE0001) begin bad++; $display("FAIL alu_fwd got=%h exp=cafe0001", bus.mem_fwd_data); end
    total++; if (bus.mem_misalign !== 1'b0) begin bad++; $display("FAIL alu_misalign got=%0b exp=0", bus.mem_misalign); end
  endtask

  task automatic test_misalign();
    put(mk_store(32'h21, 32'hAAAA5555), 1'b0, 1'b0); tick();
    total++; if (bus.mem_misalign !== 1'b1) begin bad++; $display("FAIL mis_store_flag got=%0b exp=1", bus.mem_misalign); end
    put(mk_load(32'h20), 1'b0, 1'b0); tick();
    total++; if (bus.mem_mdata !== 32'd0) begin bad++; $display("FAIL mis_dropped got=%h exp=0", bus.mem_mdata); end
    total++; if (bus.mem_misalign !== 1'b0) begin bad++; $display("FAIL mis_aligned_load got=%0b exp=0", bus.mem_misalign); end
    put(mk_store(32'h20, 32'h0BADF00D), 1'b0, 1'b0); tick();
    put(mk_load(32'h23), 1'b0, 1'b0); tick();
    total++; if (bus.mem_misalign !== 1'b1) begin bad++; $display("FAIL mis_load_flag got=%0b exp=1", bus.mem_misalign); end
    total++; if (bus.mem_mdata !== 32'h0BADF00D) begin bad++; $display("FAIL mis_load_data got=%h exp=0badf00d", bus.mem_mdata); end
  endtask

  task automatic test_stall();
    put(mk_load(32'h10), 1'b0, 1'b0); tick();
    put(mk_store(32'h8, 32'h1), 1'b1, 1'b0); #1;
    total++; if (bus.mem_wreg !== 1'b0 || bus.mem_m2reg !== 1'b0) begin bad++; $display("FAIL stall_load_bubble got=%0b%0b exp=00", bus.mem_wreg, bus.mem_m2reg); end
    tick();
    put(mk_store(32'h8, 32'h1), 1'b0, 1'b0); #1;
    total++; if (bus.mem_wreg !== 1'b1 || bus.mem_mdata !== 32'hDEADBEEF) begin bad++; $display("FAIL stall_load_release got=%0b/%h exp=1/deadbeef", bus.mem_wreg, bus.mem_mdata); end
    tick();
    for (int i = 0; i < 3; i++) begin
      put(mk_store(32'h8, 32'h55), 1'b1, 1'b0); tick();
      total++; if (bus.MEM_ins_type !== 4'd0 || bus.mem_wreg !== 1'b0) begin bad++; $display("FAIL stall_bubble cyc=%0d got type=%0d wreg=%0b exp=0/0", i, bus.MEM_ins_type, bus.mem_wreg); end
      total++; if (bus.mem_mdata !== 32'd0) begin bad++; $display("FAIL stall_nostore cyc=%0d got=%h exp=0", i, bus.mem_mdata); end
    end
    put(mk_load(32'h8), 1'b0, 1'b0); #1;
    total++; if (bus.MEM_ins_type !== 4'd2) begin bad++; $display("FAIL stall_release_type got=%0d exp=2", bus.MEM_ins_type); end
    tick();
    total++; if (bus.mem_mdata !== 32'h1) begin bad++; $display("FAIL stall_commit got=%h exp=1", bus.mem_mdata); end
    total++; if (bus.MEM_ins_number !== slot.num) begin bad++; $display("FAIL stall_next_num got=%0d exp=%0d", bus.MEM_ins_number, slot.num); end
  endtask

  task automatic test_flush();
    put(mk_store(32'h4, 32'h77), 1'b0, 1'b1); tick();
    total++; if (bus.MEM_ins_type !== 4'd0 || bus.mem_aluR !== 32'd0) begin bad++; $display("FAIL flush_bubble got type=%0d alu=%h exp=0/0", bus.MEM_ins_type, bus.mem_aluR); end
    put(mk_load(32'h4), 1'b0, 1'b0); tick();
    total++; if (bus.mem_mdata !== 32'd0) begin bad++; $display("FAIL flush_nostore got=%h exp=0", bus.mem_mdata); end
    put(mk_store(32'h4, 32'h99), 1'b0, 1'b0); tick();
    put(mk_nop(), 1'b1, 1'b1); tick();
    total++; if (bus.MEM_ins_number !== 4'd0) begin bad++; $display("FAIL flush_stall_bubble got=%0d exp=0", bus.MEM_ins_number); end
    put(mk_load(32'h4), 1'b0, 1'b0); tick();
    total++; if (bus.mem_mdata !== 32'd0) begin bad++; $display("FAIL flush_stall_nostore got=%h exp=0", bus.mem_mdata); end
  endtask

  task automatic test_random();
    ins_t x;
    bit [31:0] addr;
    bit st, fl;
    for (int c = 0; c < 400; c++) begin
      addr = $urandom_range(0, 1023);
      if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
      addr[31:10] = 22'($urandom);
      case ($urandom_range(0, 2))
        0: x = mk_store(addr, $urandom);
        1: x = mk_load(addr);
        default: x = mk_alu($urandom);
      endcase
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 9) == 0);
      put(x, st, fl);
      tick();
      total++; if (bus.mem_wreg !== (slot.wreg & !cur_stall)) begin bad++; $display("FAIL rnd_wreg c=%0d got=%0b exp=%0b", c, bus.mem_wreg, slot.wreg & !cur_stall); end
      total++; if (bus.mem_m2reg !== (slot.m2reg & !cur_stall)) begin bad++; $display("FAIL rnd_m2reg c=%0d got=%0b exp=%0b", c, bus.mem_m2reg, slot.m2reg & !cur_stall); end
      total++; if (bus.mem_aluR !== slot.alu) begin bad++; $display("FAIL rnd_aluR c=%0d got=%h exp=%h", c, bus.mem_aluR, slot.alu); end
      total++; if (bus.mem_mdata !== model_mdata()) begin bad++; $display("FAIL rnd_mdata c=%0d got=%h exp=%h", c, bus.mem_mdata, model_mdata()); end
      total++; if (bus.mem_destR !== slot.dest) begin bad++; $display("FAIL rnd_dest c=%0d got=%0d exp=%0d", c, bus.mem_destR, slot.dest); end
      total++; if (bus.MEM_ins_type !== (cur_stall ? 4'd0 : slot.typ)) begin bad++; $display("FAIL rnd_type c=%0d got=%0d exp=%0d", c, bus.MEM_ins_type, cur_stall ? 4'd0 : slot.typ); end
      total++; if (bus.MEM_ins_number !== slot.num) begin bad++; $display("FAIL rnd_num c=%0d got=%0d exp=%0d", c, bus.MEM_ins_number, slot.num); end
      if (!cur_stall) begin
        total++; if (bus.mem_fwd_data !== (slot.m2reg ? model_mdata() : slot.alu)) begin bad++; $display("FAIL rnd_fwd c=%0d got=%h exp=%h", c, bus.mem_fwd_data, slot.m2reg ? model_mdata() : slot.alu); end
        total++; if (bus.mem_misalign !== ((slot.m2reg | slot.wmem) & (slot.alu[1:0] != 2'b00))) begin bad++; $display("FAIL rnd_misalign c=%0d got=%0b", c, bus.mem_misalign); end
      end
    end
  endtask

  task automatic test_reset_mid();
    put(mk_store(32'h30, 32'hFEEDFACE), 1'b0, 1'b0); tick();
    put(mk_load(32'h30), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    total++; if (bus.mem_wreg !== 1'b0 || bus.mem_m2reg !== 1'b0 || bus.MEM_ins_type !== 4'd0) begin bad++; $display("FAIL rst_async_ctrl got=%0b%0b%0d exp=000", bus.mem_wreg, bus.mem_m2reg, bus.MEM_ins_type); end
    total++; if (bus.mem_aluR !== 32'd0 || bus.mem_fwd_data !== 32'd0 || bus.mem_mdata !== 32'd0) begin bad++; $display("FAIL rst_async_data got=%h/%h/%h exp=0", bus.mem_aluR, bus.mem_fwd_data, bus.mem_mdata); end
    @(posedge clk); #2 rst = 1'b0;
    slot = mk_nop();
    foreach (ref_mem[i]) ref_mem[i] = '0;
    put(mk_load(32'h30), 1'b0, 1'b0); tick();
    total++; if (bus.mem_mdata !== 32'd0) begin bad++; $display("FAIL rst_midstore got=%h exp=0", bus.mem_mdata); end
    for (int i = 0; i < 16; i++) begin
      put(mk_load(32'(i * 16)), 1'b0, 1'b0); tick();
      total++; if (bus.mem_mdata !== 32'd0) begin bad++; $display("FAIL rst_cleared addr=%h got=%h exp=0", slot.alu, bus.mem_mdata); end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_wrap();
    test_misalign();
    test_stall();
    test_flush();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
